// File: rtl/vga_pkg.sv
// Shared VGA constants and the RGB332 to 4:4:4 colour expansion used by the
// sync generator and the pixel fetch stage.
package vga_pkg;

  localparam int ACT_W    = 120;
  localparam int ACT_H    = 160;
  localparam int FB_DEPTH = ACT_W * ACT_H;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // Replicate the MSBs so full-scale RGB332 maps to full-scale 4-bit pins.
  function automatic rgb444_t rgb332_to_444(input logic [7:0] d);
    rgb444_t c;
    c.r = {d[7:5], d[7]};
    c.g = {d[4:2], d[4]};
    c.b = {d[1:0], d[1:0]};
    return c;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with synchronous reset; keeps sync and blank
// flags aligned with the framebuffer read latency.
module vga_delay_line #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  // NOTE: every stage is reset, not just the output, so a mid-frame reset
  // cannot release stale sync or strobe bits a few cycles later.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_pixel_fetch.sv
// Turns sync-generator timing into framebuffer reads, expands RGB332 to the
// 4:4:4 VGA pins and owns front/back buffer selection.
module vga_pixel_fetch #(
  parameter int ACT_W = vga_pkg::ACT_W,
  parameter int ACT_H = vga_pkg::ACT_H,
  parameter int OFS_W = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             px_clk,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             inframe,
  input  logic             newframe,
  input  logic             swap_req,
  output logic             swap_ack,
  output logic             front,
  output logic             fb_rd_en,
  output logic [OFS_W:0]   fb_addr,
  input  logic [7:0]       fb_rd_data,
  output logic [3:0]       vga_r,
  output logic [3:0]       vga_g,
  output logic [3:0]       vga_b,
  output logic             vga_hs,
  output logic             vga_vs,
  output logic             overrun
);

  import vga_pkg::*;

  localparam int               DEPTH    = ACT_W * ACT_H;
  localparam logic [OFS_W-1:0] LAST_OFS = OFS_W'(DEPTH - 1);

  logic             r_px_clk_q;
  logic             r_newframe_q;
  logic [OFS_W-1:0] r_ofs;
  logic             r_last_issued;
  logic             r_pending;
  logic             r_front;
  logic             r_swap_ack;
  logic             r_fb_rd_en;
  logic [OFS_W:0]   r_fb_addr;
  logic             r_overrun;
  rgb444_t          r_rgb;

  logic             w_px_en;
  logic             w_nf_rise;
  logic             w_fetch;
  logic [OFS_W-1:0] w_fetch_ofs;
  logic [1:0]       w_strobe_d;
  logic [1:0]       w_sync_d;

  assign w_px_en     = px_clk & ~r_px_clk_q;
  assign w_nf_rise   = newframe & ~r_newframe_q;
  assign w_fetch     = w_px_en & inframe;
  // A frame restart in the same cycle as a fetch reads address 0.
  assign w_fetch_ofs = w_nf_rise ? '0 : r_ofs;

  // NOTE: all state here uses non-blocking assignments so the later clear
  // and increment branches see the same pre-edge values of r_ofs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_px_clk_q    <= 1'b0;
      r_newframe_q  <= 1'b0;
      r_ofs         <= '0;
      r_last_issued <= 1'b0;
      r_fb_rd_en    <= 1'b0;
      r_fb_addr     <= '0;
      r_overrun     <= 1'b0;
    end else begin
      r_px_clk_q   <= px_clk;
      r_newframe_q <= newframe;
      r_fb_rd_en   <= w_fetch;
      if (w_nf_rise) begin
        r_ofs         <= '0;
        r_last_issued <= 1'b0;
      end
      if (w_fetch) begin
        r_fb_addr <= {r_front, w_fetch_ofs};
        if (w_fetch_ofs == LAST_OFS) begin
          // The last pixel may be read once; any further read is an overrun.
          if (r_last_issued && !w_nf_rise) r_overrun <= 1'b1;
          r_last_issued <= 1'b1;
        end else if (!w_nf_rise) begin
          r_ofs <= r_ofs + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_front    <= 1'b0;
      r_pending  <= 1'b0;
      r_swap_ack <= 1'b0;
    end else begin
      r_swap_ack <= 1'b0;
      if (w_nf_rise && (r_pending || swap_req)) begin
        r_front    <= ~r_front;
        r_pending  <= 1'b0;
        r_swap_ack <= 1'b1;
      end else if (swap_req) begin
        r_pending <= 1'b1;
      end
    end
  end

  vga_delay_line #(.DEPTH(3), .WIDTH(2)) u_sync_delay (
    .clk (clk),
    .rst (rst),
    .i_d ({hsync_in, vsync_in}),
    .o_q (w_sync_d)
  );

  // Bit 1 marks a pixel slot, bit 0 says a read was issued in that slot.
  vga_delay_line #(.DEPTH(2), .WIDTH(2)) u_blank_delay (
    .clk (clk),
    .rst (rst),
    .i_d ({w_px_en, w_fetch}),
    .o_q (w_strobe_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rgb <= '0;
    end else if (w_strobe_d[1]) begin
      r_rgb <= w_strobe_d[0] ? rgb332_to_444(fb_rd_data) : '0;
    end
  end

  assign swap_ack = r_swap_ack;
  assign front    = r_front;
  assign fb_rd_en = r_fb_rd_en;
  assign fb_addr  = r_fb_addr;
  assign overrun  = r_overrun;
  assign vga_r    = r_rgb.r;
  assign vga_g    = r_rgb.g;
  assign vga_b    = r_rgb.b;
  assign vga_hs   = w_sync_d[1];
  assign vga_vs   = w_sync_d[0];

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed bench for vga_pixel_fetch: colour table, sync alignment, full
// frame plus overrun, buffer swap and mid-frame reset.
module tb_vga_pixel_fetch;

  import vga_pkg::*;

  localparam int LAST = FB_DEPTH - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        px_clk;
  logic        hsync_in;
  logic        vsync_in;
  logic        inframe;
  logic        newframe;
  logic        swap_req;
  logic        swap_ack;
  logic        front;
  logic        fb_rd_en;
  logic [15:0] fb_addr;
  logic [7:0]  fb_rd_data;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;
  logic        vga_hs;
  logic        vga_vs;
  logic        overrun;

  int          total = 0;
  int          bad   = 0;
  logic        ram_ovr;
  logic [7:0]  ram_byte;

  typedef struct {
    logic [7:0]  data;
    logic        inf;
    logic [11:0] exp_rgb;
  } cvec_t;

  cvec_t cv [8];

  vga_pixel_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .px_clk     (px_clk),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .inframe    (inframe),
    .newframe   (newframe),
    .swap_req   (swap_req),
    .swap_ack   (swap_ack),
    .front      (front),
    .fb_rd_en   (fb_rd_en),
    .fb_addr    (fb_addr),
    .fb_rd_data (fb_rd_data),
    .vga_r      (vga_r),
    .vga_g      (vga_g),
    .vga_b      (vga_b),
    .vga_hs     (vga_hs),
    .vga_vs     (vga_vs),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // Framebuffer model: registered read, fb[i] = i[7:0] unless overridden.
  always @(posedge clk) begin
    if (fb_rd_en) fb_rd_data <= ram_ovr ? ram_byte : fb_addr[7:0];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Two-clk pixel; returns the read strobe and address seen after the fetch.
  task automatic pixel(input logic inf, output logic rd, output logic [15:0] addr);
    inframe = inf;
    px_clk  = 1'b1;
    step();
    rd   = fb_rd_en;
    addr = fb_addr;
    px_clk = 1'b0;
    step();
  endtask

  task automatic pulse_swap();
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
  endtask

  task automatic sync_edge(input logic hs, input logic vs);
    logic [1:0] old_v;
    old_v    = {hsync_in, vsync_in};
    hsync_in = hs;
    vsync_in = vs;
    step();
    check("sync_d1", 32'({vga_hs, vga_vs}), 32'(old_v));
    step();
    check("sync_d2", 32'({vga_hs, vga_vs}), 32'(old_v));
    step();
    check("sync_d3", 32'({vga_hs, vga_vs}), 32'({hs, vs}));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rgb"},  32'({vga_r, vga_g, vga_b}), 32'h0);
    check({tag, "_rden"}, 32'(fb_rd_en), 32'h0);
    check({tag, "_addr"}, 32'(fb_addr), 32'h0);
    check({tag, "_ack"},  32'(swap_ack), 32'h0);
    check({tag, "_front"}, 32'(front), 32'h0);
    check({tag, "_ovr"},  32'(overrun), 32'h0);
    check({tag, "_sync"}, 32'({vga_hs, vga_vs}), 32'h0);
  endtask

  initial begin
    logic        rd;
    logic [15:0] addr;
    logic [11:0] prev_rgb;
    int          reads;
    int          errs;
    int          front_errs;

    cv[0] = '{8'hE0, 1'b1, 12'hF00};
    cv[1] = '{8'h1C, 1'b1, 12'h0F0};
    cv[2] = '{8'h03, 1'b1, 12'h00F};
    cv[3] = '{8'hFF, 1'b0, 12'h000};
    cv[4] = '{8'hFF, 1'b1, 12'hFFF};
    cv[5] = '{8'hA5, 1'b1, 12'hB25};
    cv[6] = '{8'h49, 1'b1, 12'h445};
    cv[7] = '{8'h00, 1'b1, 12'h000};

    rst = 1'b1; px_clk = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    inframe = 1'b0; newframe = 1'b0; swap_req = 1'b0;
    ram_ovr = 1'b1; ram_byte = 8'h00;
    repeat (3) step();
    rst = 1'b0;
    check_all_zero("reset");

    // Colour table: new colour appears exactly 3 clk after px_en and holds.
    prev_rgb = 12'h000;
    for (int i = 0; i < 8; i++) begin
      ram_byte = cv[i].data;
      inframe  = cv[i].inf;
      px_clk   = 1'b1;
      step();
      check("col_rden", 32'(fb_rd_en), 32'(cv[i].inf));
      step();
      check("col_t2", 32'({vga_r, vga_g, vga_b}), 32'(prev_rgb));
      px_clk = 1'b0;
      step();
      check("col_t3", 32'({vga_r, vga_g, vga_b}), 32'(cv[i].exp_rgb));
      step();
      check("col_hold", 32'({vga_r, vga_g, vga_b}), 32'(cv[i].exp_rgb));
      prev_rgb = cv[i].exp_rgb;
    end
    inframe = 1'b0;

    sync_edge(1'b1, 1'b0);
    sync_edge(1'b1, 1'b1);
    sync_edge(1'b0, 1'b1);
    sync_edge(1'b0, 1'b0);

    // Full frame from a newframe edge, with two swap requests mid-frame.
    ram_ovr  = 1'b0;
    newframe = 1'b1;
    step();
    step();
    newframe = 1'b0;
    step();
    reads = 0; errs = 0; front_errs = 0;
    for (int i = 0; i < FB_DEPTH; i++) begin
      pixel(1'b1, rd, addr);
      if (rd) reads++;
      if (!rd || addr != {1'b0, 15'(i)}) errs++;
      if (front) front_errs++;
      if (i == 5000 || i == 6000) pulse_swap();
    end
    check("frame_reads", 32'(reads), 32'(FB_DEPTH));
    check("frame_addr_errs", 32'(errs), 32'h0);
    check("frame_front_errs", 32'(front_errs), 32'h0);
    check("frame_no_overrun", 32'(overrun), 32'h0);

    // One pixel beyond the frame: re-read the last address and flag overrun.
    pixel(1'b1, rd, addr);
    check("ovr_rden", 32'(rd), 32'h1);
    check("ovr_addr", 32'(addr), 32'(LAST));
    check("ovr_flag", 32'(overrun), 32'h1);
    inframe = 1'b0;

    newframe = 1'b1;
    step();
    check("swap_front", 32'(front), 32'h1);
    check("swap_ack", 32'(swap_ack), 32'h1);
    step();
    check("swap_ack_pulse", 32'(swap_ack), 32'h0);
    newframe = 1'b0;
    step();
    newframe = 1'b1;
    step();
    check("swap_once_ack", 32'(swap_ack), 32'h0);
    step();
    check("swap_once_front", 32'(front), 32'h1);
    newframe = 1'b0;
    step();
    check("ovr_sticky", 32'(overrun), 32'h1);

    // Partial second frame out of buffer 1, then reset at pixel 500.
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    errs = 0;
    for (int i = 0; i < 500; i++) begin
      pixel(1'b1, rd, addr);
      if (!rd || addr != {1'b1, 15'(i)}) errs++;
    end
    check("frame2_addr_errs", 32'(errs), 32'h0);
    check("frame2_bank", 32'(fb_addr[15]), 32'h1);
    inframe  = 1'b0;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all_zero("midrst");
    step();
    pixel(1'b1, rd, addr);
    check("rst_fetch0_rd", 32'(rd), 32'h1);
    check("rst_fetch0_addr", 32'(addr), 32'h0);
    pixel(1'b1, rd, addr);
    check("rst_fetch1_addr", 32'(addr), 32'h1);

    // newframe edge, swap_req and an in-frame px_en all in the same cycle.
    inframe  = 1'b1;
    newframe = 1'b1;
    swap_req = 1'b1;
    px_clk   = 1'b1;
    step();
    check("simul_addr", 32'(fb_addr), 32'h0);
    check("simul_rden", 32'(fb_rd_en), 32'h1);
    check("simul_front", 32'(front), 32'h1);
    check("simul_ack", 32'(swap_ack), 32'h1);
    swap_req = 1'b0;
    px_clk   = 1'b0;
    step();
    newframe = 1'b0;
    inframe  = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_pixel_fetch.md
# vga_pixel_fetch

Pixel fetch stage directly downstream of the VGA sync generator. It converts the generator's pixel clock, sync, `inframe` and `newframe` flags into framebuffer read requests. It expands each returned RGB332 byte to the Basys 3 4:4:4 VGA pins and delays Hsync/Vsync so they stay aligned with the colour data. It also owns front/back buffer selection for a double-buffered 120×160 framebuffer, with swaps applied only at frame boundaries.

## Interface
Parameters:
- `ACT_W`, 120: active pixels per line (matches the sync generator window).
- `ACT_H`, 160: active lines per frame.
- `OFS_W`, 15: framebuffer offset width; must satisfy 2^OFS_W ≥ ACT_W·ACT_H.

Ports:
- `clk`  in  1  100 MHz system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `px_clk`  in  1  25 MHz pixel clock from the sync generator, sampled as data on `clk`.
- `hsync_in`, `vsync_in`  in  1 each  syncs from the sync generator.
- `inframe`  in  1  active-window flag.
- `newframe`  in  1  frame-boundary flag (high for several lines).
- `swap_req`  in  1  one-cycle pulse requesting a front/back buffer swap.
- `swap_ack`  out  1  one-cycle pulse when the swap takes effect.
- `front`  out  1  current display buffer index.
- `fb_rd_en`  out  1  framebuffer read strobe.
- `fb_addr`  out  OFS_W+1  read address, formed as {front, offset}.
- `fb_rd_data`  in  8  RGB332 data, valid exactly 1 `clk` after `fb_rd_en`.
- `vga_r`, `vga_g`, `vga_b`  out  4 each  colour pins.
- `vga_hs`, `vga_vs`  out  1 each  aligned syncs.
- `overrun`  out  1  sticky error flag, cleared only by `rst`.

## Operation
- **Pixel strobe:**
  - `px_en` = `px_clk & ~px_clk_q`, where `px_clk_q` is `px_clk` registered on `clk`.
  - This gives one `clk`-wide pulse per pixel.
  - `inframe` is sampled only in `px_en` cycles.
- **Fetch:**
  - On `px_en & inframe`, register `fb_rd_en`=1 and `fb_addr`={front, ofs}, then increment `ofs`.
  - Otherwise `fb_rd_en`=0 and `fb_addr` holds its value.
  - Addressing is linear: the address for pixel (x, y) is y·ACT_W + x.
- **Frame restart:** on the rising edge of `newframe` (registered edge detect), clear `ofs` to 0.
- **Overrun:**
  - A fetch requested while `ofs` = ACT_W·ACT_H−1 already issued does not advance `ofs`; it holds at the last address and re-reads it.
  - That request also sets `overrun`.
- **Colour expansion:**
  - R = {d[7:5], d[7]}, G = {d[4:2], d[4]}, B = {d[1:0], d[1:0]}.
  - Pixels outside the window, or with no read issued, output 0x000.
- **Swap:**
  - `swap_req` sets `pending`; a `swap_req` while `pending` is already set has no further effect.
  - On the `newframe` rising edge with `pending` set (including a `swap_req` arriving that same cycle): toggle `front`, clear `pending`, pulse `swap_ack`.
  - `front` therefore never changes during the active window.

## Timing
- **Fetch pipeline:**
  - Cycle T: `px_en`.
  - T+1: `fb_rd_en`/`fb_addr` registered.
  - T+2: `fb_rd_data` valid and registered into the colour stage.
  - T+3: `vga_r/g/b` valid.
- **Sync and blank alignment:**
  - `hsync_in`/`vsync_in` pass through a 3-stage `clk` delay to `vga_hs`/`vga_vs`.
  - The blank flag (`px_en & inframe` qualified) goes through a matching 2-stage delay into the colour register.
- **Output hold:** colour outputs change only on `clk` edges following a fetch and hold for the full pixel period of 4 `clk`.
- **Reset values:**
  - All outputs are 0: `vga_*`, `fb_rd_en`, `fb_addr`, `swap_ack`, `front`, `overrun`.
  - `ofs`, `pending` and all delay stages are cleared.
- **Reset mid-frame:** the pipeline flushes to black within 1 cycle of `rst` deasserting; fetching resumes at `ofs`=0 on the next in-frame `px_en`. Addresses may be misaligned until the next `newframe` edge; this is acceptable.
- **Simultaneous `newframe` edge and `px_en & inframe`:** `ofs` clears, then the fetch uses address 0. The clear has priority over the increment.

## Structure
- Shared package `vga_pkg`:
  - Active-window constants `ACT_W`, `ACT_H`, and derived `FB_DEPTH` = 19200.
  - The RGB332-to-444 expansion function.
  - The sync generator uses the same constants.
- Sub-module `vga_delay_line`: parameterised depth/width shift register with synchronous reset, used for both the sync delay and the blank delay.

## Test plan
- **Full frame:** run 2 frames with a RAM model holding `fb[i]` = i[7:0]. Expect exactly 19200 reads per frame, addresses 0..19199, and `overrun`=0.
- **Colour expansion:** `fb_rd_data`=0xE0 gives R=0xF, G=0, B=0; 0x1C gives G=0xF; 0x03 gives B=0xF. Each appears exactly 3 `clk` after its `px_en`.
- **Sync alignment:** `vga_hs`/`vga_vs` edges occur exactly 3 `clk` after the input edges, and colour is 0 whenever `inframe` was low.
- **Swap:** a `swap_req` mid-frame gives `front`=1 and `swap_ack` one cycle after the next `newframe` rise, with `fb_addr[15]`=1 for the whole next frame. A second `swap_req` while pending still yields only one toggle.
- **Overrun:** hold `inframe` high for 19201 pixels with no `newframe`. Expect the 19201st read at address 19199 and `overrun` sticky at 1 until `rst`.
- **Reset mid-frame:** assert `rst` for 1 cycle at pixel 500. Expect all outputs 0 the next cycle and the next fetch at offset 0.
